// File: rtl/fence_t_seq_pkg.sv
// Shared types and constants for the fence.t microreset sequencer.
package fence_t_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2,
    CLEAR = 2'd3
  } fence_t_state_e;

  // fence.t is a 4-byte instruction; execution resumes right after it.
  localparam int unsigned FENCE_T_RST_OFFSET = 4;

endpackage

// File: rtl/fence_t_seq_if.sv
// Per-channel flush bundle between the fence.t sequencer and the caches/buffers.
// Handshake: flush_req[i] stays high until the channel returns a one-cycle
// flush_ack[i] pulse; busy[i] is a level meaning transactions are still in flight.
interface fence_t_seq_if #(
  parameter int unsigned NUM_CH = 2
);
  logic [NUM_CH-1:0] flush_req;
  logic [NUM_CH-1:0] flush_ack;
  logic [NUM_CH-1:0] busy;

  modport master (output flush_req, input flush_ack, input busy);
  modport slave  (input flush_req, output flush_ack, output busy);
endinterface

// File: rtl/fence_t_pad_timer.sv
// Timer-aligned pad counter: a rising edge on time_irq_i loads pad_i, after
// which the count decrements to zero and holds there.
module fence_t_pad_timer #(
  parameter int unsigned PAD_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             time_irq_i,
  input  logic [PAD_W-1:0] pad_i,
  output logic             pad_zero
);

  logic             irq_q;
  logic [PAD_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      irq_q <= time_irq_i;
      // A fresh edge always wins, even over a count still in progress.
      if (time_irq_i && !irq_q) begin
        cnt_q <= pad_i;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - PAD_W'(1);
      end
    end
  end

  assign pad_zero = (cnt_q == '0);

endmodule

// File: rtl/fence_t_seq.sv
// fence.t microreset sequencer: parallel channel flush, drain/pad wait, uarch
// clear and cache-init hold. Optional flush watchdog: FENCE_T_FLUSH_TIMEOUT_EN.
module fence_t_seq
  import fence_t_seq_pkg::*;
#(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned VLEN           = 64,
  parameter int unsigned PAD_W          = 32,
  parameter int unsigned CLR_CYCLES     = 16,
  parameter int unsigned INIT_HOLD      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             fence_t_i,
  input  logic [VLEN-1:0]  pc_commit_i,
  input  logic [VLEN-1:0]  boot_addr_i,
  input  logic             halt_i,
  fence_t_seq_if.master    flush,
  input  logic [PAD_W-1:0] pad_i,
  input  logic             time_irq_i,
  output logic             halt_o,
  output logic             busy_o,
  output logic             uarch_clr_o,
  output logic             cache_init_no,
  output logic [VLEN-1:0]  rst_addr_o,
  output logic             timeout_o,
  output fence_t_state_e   dbg_state
);

  localparam int unsigned CLR_W = $clog2(CLR_CYCLES + 1);

  if (NUM_CH < 1 || CLR_CYCLES < 1 || INIT_HOLD < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("fence_t_seq: NUM_CH, CLR_CYCLES, INIT_HOLD and TIMEOUT_CYCLES must be >= 1");
  end

  fence_t_state_e    state_q, state_d;
  logic [NUM_CH-1:0] ack_mask_q;
  logic [NUM_CH-1:0] req_q;
  logic [VLEN-1:0]   rst_addr_q;
  logic [CLR_W-1:0]  clr_cnt_q;
  logic [INIT_HOLD-1:0] init_sr_q;
  logic              rst_any;
  logic              all_ack;
  logic              pad_zero;
  logic              timeout_hit;

  assign rst_any = rst_i | clr_i;
  // A final ack arriving this cycle already completes the flush.
  assign all_ack = &(ack_mask_q | flush.flush_ack);

  fence_t_pad_timer #(.PAD_W(PAD_W)) u_pad_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_any),
    .time_irq_i (time_irq_i),
    .pad_i      (pad_i),
    .pad_zero   (pad_zero)
  );

`ifdef FENCE_T_FLUSH_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;

  assign timeout_hit = (state_q == FLUSH) && !all_ack && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign timeout_o   = timeout_hit;

  always_ff @(posedge clk_i) begin
    if (rst_any) begin
      wd_q <= '0;
    end else begin
      wd_q <= (state_q == FLUSH && state_d == FLUSH) ? wd_q + WD_W'(1) : '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_o   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (fence_t_i) state_d = FLUSH;
      FLUSH: if (all_ack || timeout_hit) state_d = DRAIN;
      DRAIN: if (flush.busy == '0 && pad_zero) state_d = CLEAR;
      CLEAR: if (clr_cnt_q == CLR_W'(CLR_CYCLES - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_any) begin
      state_q    <= IDLE;
      ack_mask_q <= '0;
      req_q      <= '0;
      rst_addr_q <= boot_addr_i;
      clr_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && fence_t_i) begin
        rst_addr_q <= pc_commit_i + VLEN'(FENCE_T_RST_OFFSET);
        ack_mask_q <= '0;
      end else if (state_q == FLUSH) begin
        ack_mask_q <= ack_mask_q | flush.flush_ack;
      end
      req_q     <= (state_q == FLUSH && state_d == FLUSH) ? ~(ack_mask_q | flush.flush_ack) : '0;
      clr_cnt_q <= (state_q == CLEAR && state_d == CLEAR) ? clr_cnt_q + CLR_W'(1) : '0;
    end
  end

  // Cache init stays suppressed while the clear ripples through, plus a tail.
  always_ff @(posedge clk_i) begin
    if (rst_any) begin
      init_sr_q <= '0;
    end else begin
      init_sr_q[0] <= uarch_clr_o;
      for (int i = 1; i < int'(INIT_HOLD); i++) begin
        init_sr_q[i] <= init_sr_q[i-1];
      end
    end
  end

  assign flush.flush_req = req_q;
  assign busy_o          = (state_q != IDLE);
  assign halt_o          = halt_i | busy_o;
  assign uarch_clr_o     = (state_q == CLEAR);
  assign cache_init_no   = |init_sr_q;
  assign rst_addr_o      = rst_addr_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_fence_t_seq.sv
// Directed bench for fence_t_seq: per-cycle vector table plus hand-written
// multi-cycle sequences for drain, pad, reset and soft-clear corners.
module tb_fence_t_seq;
  import fence_t_seq_pkg::*;

`ifdef FENCE_T_FLUSH_TIMEOUT_EN
  localparam int unsigned TMO = 8;
`else
  localparam int unsigned TMO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        fence_t;
  logic [63:0] pc;
  logic [63:0] boot;
  logic        halt_in;
  logic [31:0] pad;
  logic        irq;
  logic        halt_out;
  logic        busy_out;
  logic        uarch_clr;
  logic        init_no;
  logic [63:0] rst_addr;
  logic        timeout;
  fence_t_state_e dbg_state;

  fence_t_seq_if #(.NUM_CH(2)) flush_bus ();

  fence_t_seq #(
    .NUM_CH(2), .VLEN(64), .PAD_W(32), .CLR_CYCLES(16), .INIT_HOLD(3), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .clr_i         (clr),
    .fence_t_i     (fence_t),
    .pc_commit_i   (pc),
    .boot_addr_i   (boot),
    .halt_i        (halt_in),
    .flush         (flush_bus),
    .pad_i         (pad),
    .time_irq_i    (irq),
    .halt_o        (halt_out),
    .busy_o        (busy_out),
    .uarch_clr_o   (uarch_clr),
    .cache_init_no (init_no),
    .rst_addr_o    (rst_addr),
    .timeout_o     (timeout),
    .dbg_state     (dbg_state)
  );

  // Clock / global time limit
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "simulation time limit");
  end

  // Scoreboard
  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_rst_addr(input string name);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_queue_empty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check(name, rst_addr, e);
    end
  endtask

  // Driver tasks: inputs change just after negedge, checks 1ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic drive(input logic f, input logic [1:0] a, input logic [1:0] b);
    fence_t = f;
    flush_bus.flush_ack = a;
    flush_bus.busy = b;
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    drive(1'b0, 2'b00, 2'b00);
    while ((busy_out || init_no) && n < 300) begin
      next_cycle();
      #1;
      n++;
    end
    if (n >= 300) check({name, "_idle_timeout"}, 64'd0, 64'd1);
  endtask

  typedef struct {
    logic       fence;
    logic [1:0] ack;
    logic [1:0] req;
    logic       busy;
    logic       clr;
    logic       init;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vec_t v;
    rst = 1'b1; clr = 1'b0; fence_t = 1'b0; halt_in = 1'b0;
    pc = 64'h0; boot = 64'h1000; pad = 32'd0; irq = 1'b0;
    flush_bus.flush_ack = 2'b00; flush_bus.busy = 2'b00;
    repeat (3) next_cycle();
    #1;
    check("reset_state", 64'(dbg_state), 64'(IDLE));
    check("reset_req", 64'(flush_bus.flush_req), 64'd0);
    check("reset_clr", 64'(uarch_clr), 64'd0);
    check("reset_init", 64'(init_no), 64'd0);
    check("reset_addr", rst_addr, 64'h1000);
    check("reset_timeout", 64'(timeout), 64'd0);
    rst = 1'b0;
    next_cycle();

    // Table: fence at k0, ack ch0 at k3, ch1 at k7, DRAIN k8, CLEAR k9..k24.
    for (int k = 0; k < 29; k++) begin
      v.fence = (k == 0);
      v.ack   = (k == 3) ? 2'b01 : (k == 7) ? 2'b10 : 2'b00;
      v.req   = (k == 2 || k == 3) ? 2'b11 : (k >= 4 && k <= 7) ? 2'b10 : 2'b00;
      v.busy  = (k >= 1 && k <= 24);
      v.clr   = (k >= 9 && k <= 24);
      v.init  = (k >= 10 && k <= 27);
      vecs.push_back(v);
    end
    pc = 64'h8000_0100;
    exp_q.push_back(64'h8000_0104);
    foreach (vecs[k]) begin
      drive(vecs[k].fence, vecs[k].ack, 2'b00);
      check($sformatf("vec%0d_req", k), 64'(flush_bus.flush_req), 64'(vecs[k].req));
      check($sformatf("vec%0d_busy", k), 64'(busy_out), 64'(vecs[k].busy));
      check($sformatf("vec%0d_halt", k), 64'(halt_out), 64'(vecs[k].busy));
      check($sformatf("vec%0d_clr", k), 64'(uarch_clr), 64'(vecs[k].clr));
      check($sformatf("vec%0d_init", k), 64'(init_no), 64'(vecs[k].init));
      check($sformatf("vec%0d_timeout", k), 64'(timeout), 64'd0);
      if (k == 8) check("vec_drain_entry", 64'(dbg_state), 64'(DRAIN));
      if (k == 9) check_rst_addr("vec_rst_addr");
      next_cycle();
    end
    wait_idle("vec");

    // Simultaneous acks when requests first assert; PC wrap; fence ignored in FLUSH.
    pc = 64'hFFFF_FFFF_FFFF_FFFC;
    exp_q.push_back(64'h0);
    drive(1'b1, 2'b00, 2'b00); next_cycle();
    pc = 64'h1234;
    drive(1'b1, 2'b00, 2'b00);
    check("sim_flush_state", 64'(dbg_state), 64'(FLUSH));
    next_cycle();
    drive(1'b0, 2'b11, 2'b00);
    check("sim_req_on", 64'(flush_bus.flush_req), 64'h3);
    next_cycle();
    drive(1'b0, 2'b00, 2'b00);
    check("sim_drain", 64'(dbg_state), 64'(DRAIN));
    check("sim_req_off", 64'(flush_bus.flush_req), 64'h0);
    next_cycle(); #1;
    check("sim_clear", 64'(dbg_state), 64'(CLEAR));
    check("sim_req_off2", 64'(flush_bus.flush_req), 64'h0);
    check_rst_addr("sim_wrap_addr");
    wait_idle("sim");

    // busy_i[1] held in DRAIN cycles 3..22; CLEAR at 24.
    pc = 64'h4000;
    for (int c = 0; c <= 24; c++) begin
      drive(c == 0, (c == 2) ? 2'b11 : 2'b00, (c <= 22) ? 2'b10 : 2'b00);
      if (c >= 3 && c <= 23) begin
        check($sformatf("busy_drain_c%0d", c), 64'(dbg_state), 64'(DRAIN));
        check($sformatf("busy_halt_c%0d", c), 64'(halt_out), 64'd1);
      end
      if (c == 24) begin
        check("busy_clear_start", 64'(dbg_state), 64'(CLEAR));
        check("busy_clr_out", 64'(uarch_clr), 64'd1);
      end
      next_cycle();
    end
    wait_idle("busy");

    // Pad: irq edge at c0, DRAIN at c10, count hits zero c51, CLEAR c52.
    pad = 32'd50;
    for (int c = 0; c <= 52; c++) begin
      irq = 1'b1;
      drive(c == 7, (c == 9) ? 2'b11 : 2'b00, 2'b00);
      if (c == 10 || c == 51) check($sformatf("pad_drain_c%0d", c), 64'(dbg_state), 64'(DRAIN));
      if (c == 52) check("pad_clear", 64'(dbg_state), 64'(CLEAR));
      next_cycle();
    end
    irq = 1'b0;
    wait_idle("pad");

    // Pad reload: second edge at c20 restarts 50, CLEAR moves to c72.
    for (int c = 0; c <= 72; c++) begin
      irq = (c < 15 || c >= 20);
      drive(c == 7, (c == 9) ? 2'b11 : 2'b00, 2'b00);
      if (c == 52 || c == 71) check($sformatf("reload_drain_c%0d", c), 64'(dbg_state), 64'(DRAIN));
      if (c == 72) check("reload_clear", 64'(dbg_state), 64'(CLEAR));
      next_cycle();
    end
    irq = 1'b0;
    pad = 32'd0;
    wait_idle("reload");

    // Reset in cycle 5 of CLEAR (CLEAR starts c4).
    pc = 64'h2000;
    for (int c = 0; c <= 8; c++) begin
      drive(c == 0, (c == 2) ? 2'b11 : 2'b00, 2'b00);
      if (c == 8) begin
        check("rst_mid_clr_before", 64'(uarch_clr), 64'd1);
        rst = 1'b1;
      end
      next_cycle();
    end
    rst = 1'b0; halt_in = 1'b1;
    #1;
    check("rst_mid_clr", 64'(uarch_clr), 64'd0);
    check("rst_mid_init", 64'(init_no), 64'd0);
    check("rst_mid_addr", rst_addr, 64'h1000);
    check("rst_mid_halt_hi", 64'(halt_out), 64'd1);
    check("rst_mid_state", 64'(dbg_state), 64'(IDLE));
    halt_in = 1'b0;
    #1;
    check("rst_mid_halt_lo", 64'(halt_out), 64'd0);
    next_cycle();

    // Soft clear during FLUSH.
    drive(1'b1, 2'b00, 2'b00); next_cycle();
    drive(1'b0, 2'b00, 2'b00); next_cycle();
    drive(1'b0, 2'b00, 2'b00);
    check("clr_req_before", 64'(flush_bus.flush_req), 64'h3);
    clr = 1'b1;
    next_cycle();
    clr = 1'b0;
    #1;
    check("clr_state", 64'(dbg_state), 64'(IDLE));
    check("clr_req", 64'(flush_bus.flush_req), 64'h0);
    check("clr_busy", 64'(busy_out), 64'd0);
    check("clr_addr", rst_addr, 64'h1000);
    next_cycle();

`ifdef FENCE_T_FLUSH_TIMEOUT_EN
    // ch1 never acks: watchdog fires in FLUSH cycle 8 (c8), DRAIN at c9.
    for (int c = 0; c <= 10; c++) begin
      drive(c == 0, (c == 2) ? 2'b01 : 2'b00, 2'b00);
      if (c >= 1 && c <= 9) check($sformatf("tmo_c%0d", c), 64'(timeout), 64'(c == 8));
      if (c == 9) check("tmo_drain", 64'(dbg_state), 64'(DRAIN));
      if (c == 10) check("tmo_clear", 64'(dbg_state), 64'(CLEAR));
      next_cycle();
    end
    wait_idle("tmo");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
